// File: rtl/bp_be_pipe_long_idiv.sv
// Iterative integer divide/remainder unit for the long-latency calculator path.
// Handles DIV/DIVU/REM/REMU in full width or RV64 W-mode. Zero divisor, signed
// overflow and zero dividend resolve in the accept cycle. All other operations
// normalise on the dividend's leading zeros, then retire bits_per_iter_p
// quotient bits per cycle. The result is held until the consumer accepts it.
module bp_be_pipe_long_idiv #(
    parameter int width_p          = 64,
    parameter int bits_per_iter_p  = 1,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [1:0]                  fu_op_i,
    input  logic                        opw_v_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic [width_p-1:0]          rs1_i,
    input  logic [width_p-1:0]          rs2_i,
    input  logic                        flush_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic [width_p-1:0]          rd_data_o
);

    localparam int CNT_W = $clog2(width_p + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    // In W-mode the low 32 bits are the result and bit 31 is sign-extended.
    function automatic logic [width_p-1:0] f_sext_w(input logic [width_p-1:0] v,
                                                    input logic              w);
        return w ? {{(width_p-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Two's-complement negation when n is set.
    function automatic logic [width_p-1:0] f_cneg(input logic [width_p-1:0] v,
                                                  input logic              n);
        return n ? -v : v;
    endfunction

    // Number of significant bits in v (index of the highest set bit plus one).
    function automatic logic [CNT_W-1:0] f_bitlen(input logic [width_p-1:0] v);
        logic [CNT_W-1:0] e;
        e = '0;
        for (int i = 0; i < width_p; i++) begin
            if (v[i]) e = CNT_W'(i + 1);
        end
        return e;
    endfunction

    // Control state
    state_e                      r_state;
    logic                        r_ready;
    logic                        r_v;
    logic [reg_addr_width_p-1:0] r_rd_addr;
    logic [width_p-1:0]          r_result;

    // Captured operation and iteration datapath
    logic [1:0]                  r_op;
    logic                        r_opw;
    logic [width_p-1:0]          r_a;
    logic [width_p-1:0]          r_b;
    logic [width_p-1:0]          r_dvd;   // shifting dividend; quotient bits enter at bit 0
    logic [width_p:0]            r_rem;   // partial remainder, one spare bit for the shift-in
    logic [width_p-1:0]          r_div;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_q_neg;
    logic                        r_r_neg;

    // Accept-cycle decode: operand extension and special cases
    logic                        w_accept;
    logic                        w_signed_in;
    logic [width_p-1:0]          w_a_ext;
    logic [width_p-1:0]          w_b_ext;
    logic [width_p-1:0]          w_min_neg;
    logic                        w_b_zero;
    logic                        w_a_zero;
    logic                        w_ovf;
    logic                        w_special;
    logic [width_p-1:0]          w_spec_q;
    logic [width_p-1:0]          w_spec_r;
    logic [width_p-1:0]          w_spec_res;

    assign w_accept    = v_i & r_ready & ~flush_i;
    assign w_signed_in = ~fu_op_i[0];
    assign w_a_ext     = opw_v_i ? {{(width_p-32){w_signed_in & rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
    assign w_b_ext     = opw_v_i ? {{(width_p-32){w_signed_in & rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
    assign w_min_neg   = opw_v_i ? {{(width_p-31){1'b1}}, {31{1'b0}}}
                                 : {1'b1, {(width_p-1){1'b0}}};
    assign w_b_zero    = (w_b_ext == '0);
    assign w_a_zero    = (w_a_ext == '0);
    assign w_ovf       = w_signed_in & (w_a_ext == w_min_neg) & (w_b_ext == '1);
    assign w_special   = w_b_zero | w_ovf | w_a_zero;

    // Divide-by-zero wins over the other two cases; the zero-dividend case yields zeros.
    always_comb begin
        w_spec_q = '0;
        w_spec_r = '0;
        if (w_b_zero) begin
            w_spec_q = '1;
            w_spec_r = w_a_ext;
        end else if (w_ovf) begin
            w_spec_q = w_a_ext;
            w_spec_r = '0;
        end
    end

    assign w_spec_res = f_sext_w(fu_op_i[1] ? w_spec_r : w_spec_q, opw_v_i);

    // Normalisation: magnitudes, signs, iteration count and pre-shift
    logic                        w_signed;
    logic                        w_a_neg;
    logic                        w_b_neg;
    logic [width_p-1:0]          w_a_mag;
    logic [width_p-1:0]          w_b_mag;
    logic [CNT_W-1:0]            w_eff;
    logic [CNT_W-1:0]            w_k;
    logic [CNT_W-1:0]            w_kb;
    logic [CNT_W-1:0]            w_shamt;

    assign w_signed = ~r_op[0];
    assign w_a_neg  = w_signed & r_a[width_p-1];
    assign w_b_neg  = w_signed & r_b[width_p-1];
    assign w_a_mag  = f_cneg(r_a, w_a_neg);
    assign w_b_mag  = f_cneg(r_b, w_b_neg);
    assign w_eff    = f_bitlen(w_a_mag);
    assign w_k      = (bits_per_iter_p == 2) ? ((w_eff + CNT_W'(1)) >> 1) : w_eff;
    assign w_kb     = (bits_per_iter_p == 2) ? {w_k[CNT_W-2:0], 1'b0} : w_k;
    assign w_shamt  = CNT_W'(width_p) - w_kb;

    // Restoring shift-subtract, bits_per_iter_p steps chained per cycle
    logic [width_p:0]            w_rem_nxt;
    logic [width_p-1:0]          w_dvd_nxt;
    logic [width_p:0]            w_trial;

    always_comb begin
        w_rem_nxt = r_rem;
        w_dvd_nxt = r_dvd;
        w_trial   = '0;
        for (int s = 0; s < bits_per_iter_p; s++) begin
            w_trial   = {w_rem_nxt[width_p-1:0], w_dvd_nxt[width_p-1]};
            w_dvd_nxt = {w_dvd_nxt[width_p-2:0], 1'b0};
            if (w_trial >= {1'b0, r_div}) begin
                w_trial      = w_trial - {1'b0, r_div};
                w_dvd_nxt[0] = 1'b1;
            end
            w_rem_nxt = w_trial;
        end
    end

    // Sign fix-up and result selection
    logic [width_p-1:0]          w_fix_res;

    assign w_fix_res = f_sext_w(r_op[1] ? f_cneg(r_rem[width_p-1:0], r_r_neg)
                                        : f_cneg(r_dvd, r_q_neg), r_opw);

    // Sequencer and registered outputs; reset beats flush, flush beats everything else
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_v       <= 1'b0;
            r_rd_addr <= '0;
            r_result  <= '0;
        end else if (flush_i) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_v       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready   <= 1'b0;
                        r_rd_addr <= rd_addr_i;
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_v      <= 1'b1;
                            r_result <= w_spec_res;
                        end else begin
                            r_state  <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state  <= S_DONE;
                    r_v      <= 1'b1;
                    r_result <= w_fix_res;
                end
                S_DONE: begin
                    if (yumi_i) begin
                        r_state <= S_IDLE;
                        r_v     <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_v     <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and iteration datapath; contents are qualified by the sequencer
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op  <= fu_op_i;
            r_opw <= opw_v_i;
            r_a   <= w_a_ext;
            r_b   <= w_b_ext;
        end
        case (r_state)
            S_NORM: begin
                r_dvd   <= w_a_mag << w_shamt;
                r_div   <= w_b_mag;
                r_rem   <= '0;
                r_cnt   <= w_k - CNT_W'(1);
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
            end
            S_CALC: begin
                r_dvd <= w_dvd_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign ready_o   = r_ready;
    assign v_o       = r_v;
    assign rd_addr_o = r_rd_addr;
    assign rd_data_o = r_result;

endmodule
